// File: rtl/paddle_ctrl.sv
// paddle_ctrl: turns raw, bouncy up/down push-buttons into a clamped paddle
// top-row position. Buttons are synchronized, debounced, and fed to a small
// IDLE/UP/DOWN state machine that steps the paddle once per CLKS_PER_MOVE
// clocks while a single direction is held.
module paddle_ctrl #(
    parameter int CLKS_PER_MOVE = 250_000,
    parameter int DEBOUNCE_CLKS = 500_000,
    parameter int ACTIVE_ROWS   = 480,
    parameter int PADDLE_HEIGHT = 64
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           btn_up,
    input  logic                           btn_down,
    input  logic                           enable,
    input  logic                           recenter,
    output logic [$clog2(ACTIVE_ROWS)-1:0] pos,
    output logic                           at_top,
    output logic                           at_bottom,
    output logic                           moving
);

    localparam int PW      = $clog2(ACTIVE_ROWS);
    localparam int MAX_POS = ACTIVE_ROWS - PADDLE_HEIGHT;
    localparam int CENTER  = MAX_POS / 2;
    // Counters are at least one bit wide so degenerate settings still elaborate.
    localparam int DW      = (DEBOUNCE_CLKS > 1) ? $clog2(DEBOUNCE_CLKS) : 1;
    localparam int MW      = (CLKS_PER_MOVE > 1) ? $clog2(CLKS_PER_MOVE) : 1;

    localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CLKS - 1);
    localparam logic [MW-1:0] MOVE_LAST  = MW'(CLKS_PER_MOVE - 1);
    localparam logic [PW-1:0] POS_MAX    = PW'(MAX_POS);
    localparam logic [PW-1:0] POS_CENTER = PW'(CENTER);
    localparam logic [PW-1:0] POS_ZERO   = {PW{1'b0}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } state_t;

    // Bit 0 carries the up button, bit 1 the down button.
    logic [1:0]    raw_s;
    logic [1:0]    meta_r;
    logic [1:0]    sync_r;
    logic [1:0]    stable_r;
    logic [DW-1:0] dcnt_r [2];

    state_t        state_r;
    state_t        state_next_s;
    logic [MW-1:0] mcnt_r;
    logic [MW-1:0] mcnt_next_s;
    logic          step_s;
    logic [PW-1:0] pos_r;
    logic [PW-1:0] pos_next_s;

    assign raw_s = {btn_down, btn_up};
    assign pos   = pos_r;

    // Two-flop synchronizers; nothing downstream looks at the raw buttons.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_r <= 2'b00;
            sync_r <= 2'b00;
        end else begin
            meta_r <= raw_s;
            sync_r <= meta_r;
        end
    end

    // Debounce: accept a new level only after DEBOUNCE_CLKS consecutive disagreeing cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable_r <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                dcnt_r[i] <= {DW{1'b0}};
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sync_r[i] == stable_r[i]) begin
                    dcnt_r[i] <= {DW{1'b0}};
                end else if (dcnt_r[i] == DEB_LAST) begin
                    stable_r[i] <= sync_r[i];
                    dcnt_r[i]   <= {DW{1'b0}};
                end else begin
                    dcnt_r[i] <= dcnt_r[i] + DW'(1);
                end
            end
        end
    end

    // Next state: a single held direction moves, both/neither or disabled idles.
    always_comb begin
        state_next_s = IDLE;
        if (!enable) begin
            state_next_s = IDLE;
        end else if (stable_r[0] && !stable_r[1]) begin
            state_next_s = UP;
        end else if (stable_r[1] && !stable_r[0]) begin
            state_next_s = DOWN;
        end else begin
            state_next_s = IDLE;
        end
    end

    // Move pacing: restart on any state change or recenter, free-run while moving.
    always_comb begin
        mcnt_next_s = {MW{1'b0}};
        step_s      = 1'b0;
        if (recenter || (state_next_s != state_r)) begin
            mcnt_next_s = {MW{1'b0}};
            step_s      = 1'b0;
        end else begin
            case (state_r)
                UP, DOWN: begin
                    if (mcnt_r == MOVE_LAST) begin
                        mcnt_next_s = {MW{1'b0}};
                        step_s      = 1'b1;
                    end else begin
                        mcnt_next_s = mcnt_r + MW'(1);
                        step_s      = 1'b0;
                    end
                end
                default: begin
                    mcnt_next_s = {MW{1'b0}};
                    step_s      = 1'b0;
                end
            endcase
        end
    end

    // Position update: recenter wins over a step; steps saturate at either bound.
    always_comb begin
        pos_next_s = pos_r;
        if (recenter) begin
            pos_next_s = POS_CENTER;
        end else if (step_s && (state_r == UP) && (pos_r != POS_ZERO)) begin
            pos_next_s = pos_r - PW'(1);
        end else if (step_s && (state_r == DOWN) && (pos_r < POS_MAX)) begin
            pos_next_s = pos_r + PW'(1);
        end else begin
            pos_next_s = pos_r;
        end
    end

    // State, pacing counter, position and the flags derived from them, registered together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            mcnt_r    <= {MW{1'b0}};
            pos_r     <= POS_CENTER;
            at_top    <= 1'b0;
            at_bottom <= 1'b0;
            moving    <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            mcnt_r    <= mcnt_next_s;
            pos_r     <= pos_next_s;
            at_top    <= (pos_next_s == POS_ZERO);
            at_bottom <= (pos_next_s == POS_MAX);
            moving    <= (state_next_s != IDLE);
        end
    end

endmodule

// File: doc/paddle_ctrl.md
Name: paddle_ctrl

Overview:
- Upstream stage of the ball block. Produces the paddle top-row position (pos1 or pos2) that the ball uses for collision, and that the renderer uses for drawing.
- Instantiated once per player.
- Converts raw, asynchronous, bouncy up/down push-buttons into a clamped paddle position.
- Moves one row per CLKS_PER_MOVE clocks, the same pacing the ball uses.

Parameters:
- CLKS_PER_MOVE, 250_000: clocks between paddle steps while a direction is held.
- DEBOUNCE_CLKS, 500_000: consecutive clocks a synchronized button level must differ from its stable value before the stable value is accepted.
- ACTIVE_ROWS, 480: visible rows.
- PADDLE_HEIGHT, 64: paddle height in rows.
- Derived constants:
  - MAX_POS = ACTIVE_ROWS - PADDLE_HEIGHT.
  - CENTER = MAX_POS/2.
  - PW = $clog2(ACTIVE_ROWS).

Ports:
- clk, input, 1: system clock.
- rst, input, 1: asynchronous active-high reset.
- btn_up, input, 1: raw up button, active-high, asynchronous to clk.
- btn_down, input, 1: raw down button, active-high, asynchronous to clk.
- enable, input, 1: game running. When low, the paddle is frozen.
- recenter, input, 1: single-cycle pulse that returns the paddle to CENTER.
- pos, output, PW: paddle top row. Feeds ball pos1/pos2.
- at_top, output, 1: high when pos == 0.
- at_bottom, output, 1: high when pos == MAX_POS.
- moving, output, 1: high when the FSM is in UP or DOWN.

Behaviour:
- Reset (asynchronous, any time including mid-step):
  - pos = CENTER; state = IDLE.
  - Synchronizer flops, stable levels and all counters = 0.
  - at_top = 0, at_bottom = 0, moving = 0.
- Synchronization: each button passes through 2 flops (sync_up, sync_down). No logic reads the raw inputs.
- Debounce, per button, with its own counter dcnt (width $clog2(DEBOUNCE_CLKS)):
  - If sync == stable: dcnt <= 0.
  - Else if dcnt == DEBOUNCE_CLKS-1: stable <= sync and dcnt <= 0.
  - Else: dcnt <= dcnt+1.
  - A level change is therefore accepted only after DEBOUNCE_CLKS consecutive disagreeing cycles. Any glitch restarts the count.
- FSM, states IDLE/UP/DOWN, registered, evaluated every cycle from stable levels and enable:
  - !enable -> IDLE.
  - stable_up && !stable_down -> UP.
  - stable_down && !stable_up -> DOWN.
  - Both or neither -> IDLE.
  - Direct UP<->DOWN transitions are allowed.
- Move counter mcnt (width $clog2(CLKS_PER_MOVE)):
  - Cleared on every cycle where the next state differs from the current state, and while in IDLE.
  - In UP/DOWN: if mcnt == CLKS_PER_MOVE-1, then mcnt <= 0 and a step occurs; else mcnt <= mcnt+1.
- Steps:
  - UP step: pos <= pos-1 if pos > 0, else pos holds (no underflow wrap).
  - DOWN step: pos <= pos+1 if pos < MAX_POS, else pos holds.
  - mcnt keeps cycling while pos is pinned at a bound.
- Recenter:
  - recenter has priority over a step in the same cycle: pos <= CENTER and mcnt <= 0. The state is unchanged.
  - recenter works regardless of enable.
- Latency: from a raw button edge to the first step = 2 (sync) + DEBOUNCE_CLKS (debounce) + 1 (FSM) + CLKS_PER_MOVE rising edges. Subsequent steps occur every CLKS_PER_MOVE clocks.
- Output timing:
  - at_top, at_bottom and moving are registered alongside pos/state, so they are coherent with pos in the same cycle.
  - pos is always in [0, MAX_POS].
- Arithmetic: all pos arithmetic is PW bits unsigned. The comparisons guarantee there is no wrap.

Test Plan:
All scenarios use CLKS_PER_MOVE=4, DEBOUNCE_CLKS=3, ACTIVE_ROWS=32, PADDLE_HEIGHT=8 (MAX_POS=24, CENTER=12).
1. Reset and idle: assert rst mid-cycle, release, buttons low -> pos=12, at_top=0, at_bottom=0, moving=0, and pos stays 12 for 50 clocks.
2. Held up: btn_up high from edge 0 -> moving=1 after edge 6; pos=11 exactly at edge 10; pos decrements every 4 clocks after that; pos reaches 0 with at_top=1 and holds at 0 for 20 further clocks.
3. Glitch rejection: pulse btn_down high for 2 clocks, low, and repeat 5 times -> pos stays 12 and moving stays 0. Then hold it high for 3+ clocks -> pos steps down to 13, 14, … and saturates at 24 with at_bottom=1.
4. Both pressed: hold btn_up, then also assert btn_down -> state goes to IDLE, pos freezes, moving=0. Release btn_up -> DOWN, and the first step occurs 4 clocks after the state change (mcnt cleared).
5. Enable and recenter: move to pos=5, drop enable with btn_up held -> pos stays 5. Pulse recenter -> pos=12 on the next edge. Recenter coincident with a step while enabled -> pos=12, not 11 or 13.
6. Reset mid-move: rst asserted while in UP with mcnt=2 and pos=9 -> pos=12 immediately (asynchronously) and moving=0. After release, movement restarts only after the full debounce + move latency.
